// File: rtl/rv_iommu_wsi_gen.sv
// rv_iommu_wsi_gen: maps N_SRC interrupt causes onto N_INT_VEC wires.
// Each cause is routed by its vector index, and causes that share a wire are ORed.
// Wires can be driven as a registered level, or as a fixed-width pulse that is
// followed by a programmable holdoff gap.
// Optional feature macro: RV_IOMMU_WSI_PULSE_EN. When it is undefined, only
// level mode is built, mode_i/holdoff_i are ignored and busy_o is 0.
//
// Per-wire FSM in pulse mode (state visible through busy_o = state != IDLE):
//   IDLE  -> PULSE on a rising request edge.
//   PULSE -> HOLD after PULSE_W cycles. If holdoff is 0, it goes straight to
//            PULSE (when an edge was missed) or to IDLE.
//   HOLD  -> PULSE if an edge was missed, else IDLE, after holdoff cycles.
// Rising edges that arrive in PULSE/HOLD collapse into one "missed" re-fire.
module rv_iommu_wsi_gen #(
  parameter int N_SRC     = 4,
  parameter int N_INT_VEC = 16,
  parameter int VEC_W     = 4,
  parameter int PULSE_W   = 4,
  parameter int HOLD_W    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_SRC-1:0]         src_pend_i,
  input  logic [N_SRC-1:0]         src_en_i,
  input  logic [N_SRC*VEC_W-1:0]   ivec_i,
  input  logic                     mode_i,
  input  logic [HOLD_W-1:0]        holdoff_i,
  output logic [N_INT_VEC-1:0]     wsi_wires_o,
  output logic [N_INT_VEC-1:0]     busy_o
);

  logic [N_INT_VEC-1:0] req;
  logic [N_INT_VEC-1:0] wire_q;

  assign wsi_wires_o = wire_q;

  // Per-wire request: OR of enabled pending causes whose index selects the wire.
  // An index >= N_INT_VEC matches no wire.
  always_comb begin
    req = '0;
    for (int w = 0; w < N_INT_VEC; w++) begin
      for (int k = 0; k < N_SRC; k++) begin
        if (src_pend_i[k] && src_en_i[k] &&
            (int'(ivec_i[k*VEC_W +: VEC_W]) == w)) begin
          req[w] = 1'b1;
        end
      end
    end
  end

`ifdef RV_IOMMU_WSI_PULSE_EN

  localparam int CNT_W = ($clog2(PULSE_W) > HOLD_W) ? $clog2(PULSE_W) : HOLD_W;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } wsi_state_e;

  wsi_state_e           state_q [N_INT_VEC];
  wsi_state_e           state_d [N_INT_VEC];
  logic [CNT_W-1:0]     cnt_q   [N_INT_VEC];
  logic [CNT_W-1:0]     cnt_d   [N_INT_VEC];
  logic [N_INT_VEC-1:0] missed_q, missed_d;
  logic [N_INT_VEC-1:0] req_q;
  logic [N_INT_VEC-1:0] wire_d;
  logic [N_INT_VEC-1:0] rise;
  logic                 mode_q;
  logic                 mode_chg;

  assign rise     = req & ~req_q;
  assign mode_chg = mode_i ^ mode_q;

  // Per-wire next state. A mode change or level mode parks every FSM in IDLE.
  always_comb begin
    wire_d = '0;
    for (int w = 0; w < N_INT_VEC; w++) begin
      state_d[w]  = state_q[w];
      cnt_d[w]    = cnt_q[w];
      missed_d[w] = missed_q[w];
      if (mode_chg || !mode_i) begin
        state_d[w]  = ST_IDLE;
        cnt_d[w]    = '0;
        missed_d[w] = 1'b0;
      end else begin
        case (state_q[w])
          ST_IDLE: begin
            if (rise[w]) begin
              state_d[w] = ST_PULSE;
              cnt_d[w]   = PULSE_LOAD;
            end
          end
          ST_PULSE: begin
            if (cnt_q[w] == '0) begin
              if (holdoff_i == '0) begin
                if (missed_q[w] || rise[w]) begin
                  state_d[w]  = ST_PULSE;
                  cnt_d[w]    = PULSE_LOAD;
                  missed_d[w] = 1'b0;
                end else begin
                  state_d[w] = ST_IDLE;
                end
              end else begin
                // holdoff is captured here only; later changes do not stretch the gap
                state_d[w]  = ST_HOLD;
                cnt_d[w]    = CNT_W'(holdoff_i) - CNT_W'(1);
                missed_d[w] = missed_q[w] | rise[w];
              end
            end else begin
              cnt_d[w]    = cnt_q[w] - CNT_W'(1);
              missed_d[w] = missed_q[w] | rise[w];
            end
          end
          ST_HOLD: begin
            if (cnt_q[w] == '0) begin
              // an edge on the exit cycle counts as missed
              if (missed_q[w] || rise[w]) begin
                state_d[w]  = ST_PULSE;
                cnt_d[w]    = PULSE_LOAD;
                missed_d[w] = 1'b0;
              end else begin
                state_d[w] = ST_IDLE;
              end
            end else begin
              cnt_d[w]    = cnt_q[w] - CNT_W'(1);
              missed_d[w] = missed_q[w] | rise[w];
            end
          end
          default: begin
            state_d[w] = ST_IDLE;
            cnt_d[w]   = '0;
          end
        endcase
      end
      if (!mode_chg) begin
        wire_d[w] = mode_i ? (state_d[w] == ST_PULSE) : req[w];
      end
    end
  end

  // State, counters, edge history and registered wires.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int w = 0; w < N_INT_VEC; w++) begin
        state_q[w] <= ST_IDLE;
        cnt_q[w]   <= '0;
      end
      missed_q <= '0;
      req_q    <= '0;
      wire_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      for (int w = 0; w < N_INT_VEC; w++) begin
        state_q[w] <= state_d[w];
        cnt_q[w]   <= cnt_d[w];
      end
      missed_q <= missed_d;
      req_q    <= req;
      wire_q   <= wire_d;
      mode_q   <= mode_i;
    end
  end

  // busy reflects a non-IDLE FSM; always 0 in level mode since FSMs are parked.
  always_comb begin
    for (int w = 0; w < N_INT_VEC; w++) begin
      busy_o[w] = (state_q[w] != ST_IDLE);
    end
  end

`else

  logic unused_cfg;
  assign unused_cfg = ^{mode_i, holdoff_i};
  assign busy_o     = '0;

  // Level-only build: wires follow the request with one cycle of latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wire_q <= '0;
    end else begin
      wire_q <= req;
    end
  end

`endif

endmodule

// File: tb/tb_rv_iommu_wsi_gen.sv
// Bench for rv_iommu_wsi_gen: directed scenarios plus random stimulus. Both are
// checked against a time-window model of the wire behaviour.
module tb_rv_iommu_wsi_gen;

  localparam int N_SRC  = 4;
  localparam int NV     = 10;
  localparam int VEC_W  = 4;
  localparam int PW     = 4;
  localparam int HOLD_W = 8;
`ifdef RV_IOMMU_WSI_PULSE_EN
  localparam bit PULSE_BUILT = 1'b1;
`else
  localparam bit PULSE_BUILT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_SRC-1:0]       pend, en;
  logic [N_SRC*VEC_W-1:0] ivec;
  logic                   mode;
  logic [HOLD_W-1:0]      hold;
  logic [NV-1:0]          wires, busy;

  rv_iommu_wsi_gen #(
    .N_SRC(N_SRC), .N_INT_VEC(NV), .VEC_W(VEC_W), .PULSE_W(PW), .HOLD_W(HOLD_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .src_pend_i(pend), .src_en_i(en), .ivec_i(ivec),
    .mode_i(mode), .holdoff_i(hold), .wsi_wires_o(wires), .busy_o(busy)
  );

  // ---------------- scoreboard ----------------
  logic [2*NV-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [NV-1:0] obs_wires, obs_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each wire keeps its current pulse as a window of cycles [p_start, p_end].
  // The busy window ends at h_end. Model cycle t uses the inputs of cycle t and
  // predicts the outputs for cycle t+1.
  logic [NV-1:0] m_req_prev;
  logic          m_mode_prev;
  longint        p_start[NV], p_end[NV], h_end[NV];
  bit            m_missed[NV];
  longint        cyc;

  task automatic model_reset();
    m_req_prev  = '0;
    m_mode_prev = 1'b0;
    cyc         = 0;
    for (int w = 0; w < NV; w++) begin
      p_start[w] = 1; p_end[w] = 0; h_end[w] = 0; m_missed[w] = 1'b0;
    end
  endtask

  task automatic model_cycle();
    logic [NV-1:0] r, e, ew, eb;
    longint t;
    int idx;
    bit eff_mode, chg, busy_t;
    r = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(ivec[k*VEC_W +: VEC_W]);
      if (pend[k] && en[k] && idx < NV) r[idx] = 1'b1;
    end
    e        = r & ~m_req_prev;
    eff_mode = PULSE_BUILT ? mode : 1'b0;
    chg      = PULSE_BUILT && (mode != m_mode_prev);
    t        = cyc;
    ew = '0;
    eb = '0;
    for (int w = 0; w < NV; w++) begin
      if (chg || !eff_mode) begin
        p_start[w] = 1; p_end[w] = 0; h_end[w] = 0; m_missed[w] = 1'b0;
      end else begin
        busy_t = (p_start[w] <= t) && (t <= h_end[w]);
        if (!busy_t) begin
          if (e[w]) begin
            p_start[w] = t + 1; p_end[w] = t + PW; h_end[w] = t + PW;
          end
        end else if (t == p_end[w]) begin
          if (hold == 0) begin
            if (m_missed[w] || e[w]) begin
              p_start[w] = t + 1; p_end[w] = t + PW; h_end[w] = t + PW;
              m_missed[w] = 1'b0;
            end
          end else begin
            h_end[w] = t + longint'(hold);
            if (e[w]) m_missed[w] = 1'b1;
          end
        end else if (t == h_end[w]) begin
          if (m_missed[w] || e[w]) begin
            p_start[w] = t + 1; p_end[w] = t + PW; h_end[w] = t + PW;
            m_missed[w] = 1'b0;
          end
        end else if (e[w]) begin
          m_missed[w] = 1'b1;
        end
      end
      if (!chg) begin
        ew[w] = eff_mode ? ((p_start[w] <= t + 1) && (t + 1 <= p_end[w])) : r[w];
      end
      eb[w] = (p_start[w] <= t + 1) && (t + 1 <= h_end[w]);
    end
    exp_q.push_back({ew, eb});
    m_req_prev  = r;
    m_mode_prev = mode;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: check outputs against the prediction, then drive new inputs.
  task automatic step(input logic [N_SRC-1:0] p, input logic [N_SRC-1:0] e_i,
                      input logic [15:0] iv, input logic m, input logic [HOLD_W-1:0] h);
    logic [2*NV-1:0] x;
    @(posedge clk);
    #1;
    obs_wires = wires;
    obs_busy  = busy;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("wires", {22'd0, wires}, {22'd0, x[2*NV-1:NV]});
      check("busy",  {22'd0, busy},  {22'd0, x[NV-1:0]});
    end
    pend = p; en = e_i; ivec = iv; mode = m; hold = h;
    model_cycle();
  endtask

  task automatic idle(input int n, input logic m, input logic [HOLD_W-1:0] h);
    for (int i = 0; i < n; i++) step(4'b0000, 4'hF, 16'h0002, m, h);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop right away.
  task automatic reset_mid(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_wires"}, {22'd0, wires}, 32'd0);
    check({tag, "_busy"},  {22'd0, busy},  32'd0);
    pend = '0; en = '0; ivec = '0; mode = 1'b0; hold = '0;
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    model_cycle();
  endtask

  // Drive cause 0 (-> wire 2) from a pend bit mask; trace wire/busy bit 2.
  task automatic run_trace(input string tag, input logic [31:0] mask, input int n,
                           input logic [HOLD_W-1:0] h,
                           input logic [31:0] exp_w, input logic [31:0] exp_b);
    logic [31:0] tw, tbsy;
    tw = '0;
    tbsy = '0;
    for (int i = 0; i < n; i++) begin
      step(mask[i] ? 4'b0001 : 4'b0000, 4'hF, 16'h0002, 1'b1, h);
      tw[i]   = obs_wires[2];
      tbsy[i] = obs_busy[2];
    end
    check({tag, "_wire"}, tw, exp_w);
    check({tag, "_busy"}, tbsy, exp_b);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N_SRC-1:0] rp, re;
    logic [15:0]      riv;
    logic             rm;

    pend = '0; en = '0; ivec = '0; mode = 1'b0; hold = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wires", {22'd0, wires}, 32'd0);
    check("rst_busy",  {22'd0, busy},  32'd0);
    #2;
    rst = 1'b0;
    model_cycle();

    // level: ivec = {3,3,1,0}, cause 2 -> wire 3
    step(4'b0100, 4'hF, 16'h3310, 1'b0, 8'd0);
    step(4'b0100, 4'hF, 16'h3310, 1'b0, 8'd0);
    check("lvl_hit", {22'd0, obs_wires}, 32'h008);
    step(4'b0000, 4'hF, 16'h3310, 1'b0, 8'd0);
    step(4'b0000, 4'hF, 16'h3310, 1'b0, 8'd0);
    check("lvl_clear", {22'd0, obs_wires}, 32'h000);

    // out-of-range indices and the top legal wire
    step(4'b0001, 4'h1, 16'h000C, 1'b0, 8'd0);
    step(4'b0001, 4'h1, 16'h000C, 1'b0, 8'd0);
    check("oor_12", {22'd0, obs_wires}, 32'h000);
    step(4'b0001, 4'h1, 16'h000A, 1'b0, 8'd0);
    step(4'b0001, 4'h1, 16'h000A, 1'b0, 8'd0);
    check("oor_10", {22'd0, obs_wires}, 32'h000);
    step(4'b0001, 4'h1, 16'h0009, 1'b0, 8'd0);
    step(4'b0001, 4'h1, 16'h0009, 1'b0, 8'd0);
    check("top_wire", {22'd0, obs_wires}, 32'h200);

    if (PULSE_BUILT) begin
      idle(12, 1'b1, 8'd3);
      run_trace("pulse_basic", 32'hFFFF_FFFF, 16, 8'd3, 32'h0000_001E, 32'h0000_00FE);
      idle(12, 1'b1, 8'd3);
      run_trace("missed", 32'hFFFF_EFFD, 32, 8'd3, 32'h0007_8F1E, 32'h003F_FFFE);
      idle(12, 1'b1, 8'd0);
      run_trace("hold0", 32'h0000_FFFD, 16, 8'd0, 32'h0000_01FE, 32'h0000_01FE);

      // mode switch to level in the middle of a pulse
      idle(12, 1'b1, 8'd3);
      step(4'b0001, 4'hF, 16'h0002, 1'b1, 8'd3);
      step(4'b0001, 4'hF, 16'h0002, 1'b1, 8'd3);
      step(4'b0001, 4'hF, 16'h0002, 1'b0, 8'd3);
      check("msw_pulse", {31'd0, obs_wires[2]}, 32'd1);
      step(4'b0001, 4'hF, 16'h0002, 1'b0, 8'd3);
      check("msw_low",  {22'd0, obs_wires}, 32'h000);
      check("msw_busy", {22'd0, obs_busy},  32'h000);
      step(4'b0001, 4'hF, 16'h0002, 1'b0, 8'd3);
      check("msw_level", {22'd0, obs_wires}, 32'h004);

      // asynchronous reset mid-pulse, then mid-hold
      idle(12, 1'b1, 8'd3);
      for (int i = 0; i < 3; i++) step(4'b0001, 4'hF, 16'h0002, 1'b1, 8'd3);
      check("pre_rst_wire", {31'd0, obs_wires[2]}, 32'd1);
      reset_mid("rst_pulse");
      idle(12, 1'b1, 8'd5);
      for (int i = 0; i < 7; i++) step(4'b0001, 4'hF, 16'h0002, 1'b1, 8'd5);
      check("hold_busy", {31'd0, obs_busy[2]}, 32'd1);
      reset_mid("rst_hold");
    end else begin
      idle(4, 1'b1, 8'd2);
      step(4'b0001, 4'hF, 16'h0002, 1'b1, 8'd2);
      step(4'b0001, 4'hF, 16'h0002, 1'b1, 8'd2);
      check("nopulse_lvl",  {22'd0, obs_wires}, 32'h004);
      check("nopulse_busy", {22'd0, obs_busy},  32'h000);
      step(4'b0000, 4'hF, 16'h0002, 1'b1, 8'd2);
      step(4'b0000, 4'hF, 16'h0002, 1'b1, 8'd2);
      check("nopulse_clr", {22'd0, obs_wires}, 32'h000);
      reset_mid("rst_level");
    end

    // random phase
    rp = '0; re = 4'hF; riv = 16'h7352; rm = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) riv = 16'($urandom);
      if ($urandom_range(0, 31) == 0) re  = 4'($urandom);
      if ($urandom_range(0, 59) == 0) rm  = ~rm;
      rp = rp ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      step(rp, re, riv, rm, 8'($urandom_range(0, 6)));
    end
    step(4'b0000, 4'hF, 16'h0002, rm, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
